// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add MUL, restoring DIV.
// Optional macro FAST_MUL_EN: single-cycle multiplier for the MUL* ops.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_o,
  output logic            rf_we
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rdl_q, rdl_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic        an_q, an_d;
  logic        bn_q, bn_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rdo_q, rdo_d;

  logic        a_sgn, b_sgn;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        launch;
  logic        fast_go;
  logic [31:0] fast_res;

  always_comb begin
    a_sgn = funct3[2] ? !funct3[0] : !(funct3[1] & funct3[0]);
    b_sgn = funct3[2] ? !funct3[0] : !funct3[1];
    a_neg = a_sgn & rs1_val[31];
    b_neg = b_sgn & rs2_val[31];
    a_mag = a_neg ? -rs1_val : rs1_val;
    b_mag = b_neg ? -rs2_val : rs2_val;
    launch = start && !flush;
  end

`ifdef FAST_MUL_EN
  logic signed [63:0] fa, fb, fp;

  always_comb begin
    fa = {{32{a_sgn & rs1_val[31]}}, rs1_val};
    fb = {{32{b_sgn & rs2_val[31]}}, rs2_val};
    fp = fa * fb;
    fast_go = !funct3[2];
    fast_res = (funct3[1:0] == 2'b00) ? fp[31:0] : fp[63:32];
  end
`else
  always_comb begin
    fast_go = 1'b0;
    fast_res = '0;
  end
`endif

  // One iteration of each algorithm on the shared accumulator
  logic [32:0] msum;
  logic [63:0] mul_step;
  logic [32:0] rsh, dsub;
  logic [63:0] div_step;

  always_comb begin
    msum = {1'b0, acc_q[63:32]}
         + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    mul_step = {msum, acc_q[31:1]};
    rsh  = {acc_q[63:32], acc_q[31]};
    dsub = rsh - {1'b0, b_q};
    div_step = dsub[32]
             ? {rsh[31:0], acc_q[30:0], 1'b0}
             : {dsub[31:0], acc_q[30:0], 1'b1};
  end

  logic [63:0] prod;
  logic [31:0] qv, rv, a_orig;
  logic        b_zero;
  logic [31:0] fin_res;

  always_comb begin
    prod   = (an_q ^ bn_q) ? -acc_q : acc_q;
    qv     = (an_q ^ bn_q) ? -acc_q[31:0] : acc_q[31:0];
    rv     = an_q ? -acc_q[63:32] : acc_q[63:32];
    a_orig = an_q ? -a_q : a_q;
    b_zero = (b_q == 32'd0);
    unique case (1'b1)
      !op_q[2] && (op_q[1:0] == 2'b00): fin_res = prod[31:0];
      !op_q[2] && (op_q[1:0] != 2'b00): fin_res = prod[63:32];
      op_q[2] && !op_q[1]: fin_res = b_zero ? 32'hFFFF_FFFF : qv;
      default: fin_res = b_zero ? a_orig : rv;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rdl_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      an_q     <= 1'b0;
      bn_q     <= 1'b0;
      result_q <= '0;
      rdo_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rdl_q    <= rdl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      an_q     <= an_d;
      bn_q     <= bn_d;
      result_q <= result_d;
      rdo_q    <= rdo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (launch) state_d = fast_go ? S_DONE : S_CALC;
      S_CALC: if (cnt_q[5]) state_d = S_FIN;
      S_FIN:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    rdl_d    = rdl_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    an_d     = an_q;
    bn_d     = bn_q;
    result_d = result_q;
    rdo_d    = rdo_q;
    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          op_d  = funct3;
          rdl_d = rd_i;
          a_d   = a_mag;
          b_d   = b_mag;
          an_d  = a_neg;
          bn_d  = b_neg;
          acc_d = {32'd0, funct3[2] ? a_mag : b_mag};
          cnt_d = '0;
          if (fast_go) begin
            result_d = fast_res;
            rdo_d    = rd_i;
          end
        end
      end
      S_CALC: begin
        // cnt_q[5] marks the drain cycle after the 32nd step
        if (!cnt_q[5]) begin
          acc_d = op_q[2] ? div_step : mul_step;
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_FIN: begin
        if (!flush) begin
          result_d = fin_res;
          rdo_d    = rdl_q;
        end
      end
      S_DONE: cnt_d = '0;
      default: ;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    rf_we  = done && (rdo_q != 5'd0);
    result = result_q;
    rd_o   = rdo_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a latency/result model.
// Compare process checks every output on every cycle after reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [4:0]  rd_i;
  logic [31:0] rs1_val, rs2_val;
  logic        busy, done, rf_we;
  logic [31:0] result;
  logic [4:0]  rd_o;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .funct3(funct3), .rd_i(rd_i),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .busy(busy), .done(done), .result(result),
    .rd_o(rd_o), .rf_we(rf_we)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int si, sj;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    si = a;
    sj = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return si / sj;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return si % sj;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f3);
`ifdef FAST_MUL_EN
    return f3[2] ? 34 : 0;
`else
    return 34;
`endif
  endfunction

  // Model: pending op with remaining edges until its result is visible
  bit          m_pend;
  int          m_rem;
  logic [31:0] m_res, p_res;
  logic [4:0]  m_rd, p_rd;
  int          lat_v;

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_rem  <= 0;
      m_res  <= '0;
      m_rd   <= '0;
    end else if (flush) begin
      m_pend <= 1'b0;
    end else if (!m_pend) begin
      if (start) begin
        lat_v = lat_of(funct3);
        m_pend <= 1'b1;
        m_rem  <= lat_v;
        p_res  <= ref_op(funct3, rs1_val, rs2_val);
        p_rd   <= rd_i;
        if (lat_v == 0) begin
          m_res <= ref_op(funct3, rs1_val, rs2_val);
          m_rd  <= rd_i;
        end
      end
    end else if (m_rem == 0) begin
      m_pend <= 1'b0;
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_res <= p_res;
        m_rd  <= p_rd;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_pend});
      chk("done", {31'd0, done}, {31'd0, m_pend && m_rem == 0});
      chk("rf_we", {31'd0, rf_we},
          {31'd0, m_pend && m_rem == 0 && m_rd != 0});
      chk("result", result, m_res);
      chk("rd_o", {27'd0, rd_o}, {27'd0, m_rd});
    end
  end

  task automatic launch(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_i = rd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] lit, input bit use_lit);
    bit ok;
    if (use_lit) chk("model_pin", ref_op(f3, a, b), lit);
    launch(f3, a, b, rd);
    wait_done(ok);
    if (ok && use_lit) begin
      chk("lit_result", result, lit);
      chk("lit_rd", {27'd0, rd_o}, {27'd0, rd});
      chk("lit_we", {31'd0, rf_we}, {31'd0, rd != 0});
    end
    @(negedge clk);
  endtask

  initial begin
    int dcnt;
    bit ok;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; rd_i = '0; rs1_val = '0; rs2_val = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFA, 5'd5, 32'hFFFF_FFD6, 1);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 1);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'h7FFF_FFFC, 1);
    run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'd1, 1);
    run_op(3'd4, 32'h1234, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
    run_op(3'd6, 32'h1234, 32'd0, 5'd15, 32'h1234, 1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, 1);
    run_op(3'd5, 32'd100, 32'd0, 5'd19, 32'hFFFF_FFFF, 1);
    run_op(3'd7, 32'd100, 32'd0, 5'd20, 32'd100, 1);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd21, 32'd1, 1);
    run_op(3'd0, 32'd0, 32'hDEAD_BEEF, 5'd1, 32'd0, 1);
    run_op(3'd0, 32'd2, 32'd3, 5'd0, 32'd6, 1);
    for (int i = 0; i < 8; i++)
      run_op(3'($urandom_range(7)), $urandom, $urandom,
             5'($urandom_range(31)), 32'd0, 0);
    run_op(3'd0, 32'd3, 32'd5, 5'd9, 32'd15, 1);

    // flush at E10, with a second start ignored while busy
    launch(3'd4, 32'd1000, 32'd7, 5'd12);
    repeat (3) @(negedge clk);
    start = 1'b1; rd_i = 5'd17;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("flush_nodone", dcnt, 32'd0);
    chk("flush_result", result, 32'd15);
    chk("flush_rd", {27'd0, rd_o}, 32'd9);

    // flush and start together in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; rd_i = 5'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);

    // flush during the done cycle keeps the pulse
    launch(3'd5, 32'd50, 32'd5, 5'd22);
    wait_done(ok);
    flush = 1'b1;
    if (ok) chk("flush_done_res", result, 32'd10);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_busy", {31'd0, busy}, 32'd0);

    // reset mid-operation
    launch(3'd4, 32'd77, 32'd3, 5'd23);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_rd", {27'd0, rd_o}, 32'd0);
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
